// File: rtl/bot_port_master.sv
// bot_port_master: initiator for the 8-bit PicoBlaze-style port bus.
// Turns a valid/ready command stream into single INPUT/OUTPUT cycles with
// KCPSM6 timing (address cycle, then strobe cycle) and services the
// responder's level interrupt with a one-cycle ack followed by a guard cycle.
module bot_port_master #(
    parameter bit IRQ_EN = 1'b1,
    parameter bit KW_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_kwrite,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    input  logic [7:0] in_port,
    output logic       write_strobe,
    output logic       k_write_strobe,
    output logic       read_strobe,
    input  logic       interrupt,
    output logic       interrupt_ack,
    output logic       irq_event
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STRB,
        IACK,
        IGRD
    } state_t;

    state_t state;
    state_t state_next;

    logic op_write;
    logic op_kwrite;
    logic irq_req;
    logic accept;

    assign irq_req = IRQ_EN && interrupt;

    // Next-state decode and single-cycle qualifiers derived from the current state
    always_comb begin
        state_next     = state;
        cmd_ready      = 1'b0;
        accept         = 1'b0;
        write_strobe   = 1'b0;
        k_write_strobe = 1'b0;
        read_strobe    = 1'b0;
        interrupt_ack  = 1'b0;
        irq_event      = 1'b0;
        case (state)
            IDLE: begin
                if (irq_req) begin
                    state_next = IACK;
                end else begin
                    cmd_ready = rst;
                    if (cmd_valid && rst) begin
                        accept     = 1'b1;
                        state_next = ADDR;
                    end
                end
            end
            ADDR: begin
                state_next = STRB;
            end
            STRB: begin
                read_strobe    = !op_write;
                k_write_strobe = op_write && op_kwrite;
                write_strobe   = op_write && !op_kwrite;
                state_next     = IDLE;
            end
            IACK: begin
                interrupt_ack = 1'b1;
                irq_event     = 1'b1;
                state_next    = IGRD;
            end
            IGRD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, bus address/data latches and read-response capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            port_id   <= 8'h00;
            out_port  <= 8'h00;
            op_write  <= 1'b0;
            op_kwrite <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_next;
            rsp_valid <= (state == STRB) && !op_write;
            if (accept) begin
                port_id   <= cmd_port;
                op_write  <= cmd_write;
                op_kwrite <= KW_EN && cmd_write && cmd_kwrite;
                if (cmd_write) begin
                    out_port <= cmd_data;
                end
            end
            if ((state == STRB) && !op_write) begin
                rsp_data <= in_port;
            end
        end
    end

endmodule

// File: tb/tb_bot_port_master.sv
// tb_bot_port_master: directed scenarios plus randomized traffic against a
// cycle-schedule reference model. Two instances share all inputs: dut0 with
// KW_EN=1 and dut1 with KW_EN=0.
module tb_bot_port_master;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_write;
    logic       cmd_kwrite;
    logic [7:0] cmd_port;
    logic [7:0] cmd_data;
    logic       interrupt;

    logic       cmd_ready0, rsp_valid0, write_strobe0, k_write_strobe0, read_strobe0;
    logic       interrupt_ack0, irq_event0;
    logic [7:0] rsp_data0, port_id0, out_port0, in_port0;
    logic       cmd_ready1, rsp_valid1, write_strobe1, k_write_strobe1, read_strobe1;
    logic       interrupt_ack1, irq_event1;
    logic [7:0] rsp_data1, port_id1, out_port1, in_port1;

    logic [7:0] regs [256];

    int checkCount = 0;
    int errorCount = 0;
    int ackCount0 = 0;
    bit ackDelay = 1'b0;

    // Reference model state: cycle numbers at which each event is due
    int cyc = 0;
    int nextFree = 0;
    int strobeAt = -1;
    int ackAt = -1;
    int rspAt = -1;
    int rdAt = -1;
    bit opW = 1'b0;
    bit opK = 1'b0;
    bit modelValid = 1'b0;
    logic [7:0] expPort = 8'h00;
    logic [7:0] expOut = 8'h00;
    logic [7:0] expRsp = 8'h00;

    bot_port_master #(.IRQ_EN(1'b1), .KW_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_write(cmd_write), .cmd_kwrite(cmd_kwrite),
        .cmd_port(cmd_port), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
        .port_id(port_id0), .out_port(out_port0), .in_port(in_port0),
        .write_strobe(write_strobe0), .k_write_strobe(k_write_strobe0),
        .read_strobe(read_strobe0),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack0), .irq_event(irq_event0)
    );

    bot_port_master #(.IRQ_EN(1'b1), .KW_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_write(cmd_write), .cmd_kwrite(cmd_kwrite),
        .cmd_port(cmd_port), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .port_id(port_id1), .out_port(out_port1), .in_port(in_port1),
        .write_strobe(write_strobe1), .k_write_strobe(k_write_strobe1),
        .read_strobe(read_strobe1),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack1), .irq_event(irq_event1)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder register file: in_port follows port_id one cycle later
    always @(posedge clk) begin
        in_port0 <= regs[port_id0];
        in_port1 <= regs[port_id1];
    end

    // Count acknowledges seen on dut0
    always @(negedge clk) begin
        if (interrupt_ack0 === 1'b1) ackCount0++;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: a free master accepts or acks; each job books its future events
    always @(posedge clk) begin
        if (!rst) begin
            modelValid = 1'b1;
            nextFree = cyc + 1;
            strobeAt = -1;
            ackAt = -1;
            rspAt = -1;
            rdAt = -1;
            expPort = 8'h00;
            expOut = 8'h00;
            expRsp = 8'h00;
        end else if (modelValid) begin
            if (rdAt == cyc) expRsp = regs[expPort];
            if (cyc >= nextFree) begin
                if (interrupt) begin
                    ackAt = cyc + 1;
                    nextFree = cyc + 3;
                end else if (cmd_valid) begin
                    expPort = cmd_port;
                    if (cmd_write) expOut = cmd_data;
                    opW = cmd_write;
                    opK = cmd_kwrite;
                    strobeAt = cyc + 2;
                    if (!cmd_write) begin
                        rdAt = cyc + 2;
                        rspAt = cyc + 3;
                    end
                    nextFree = cyc + 3;
                end
            end
        end
        cyc++;
    end

    task automatic checkDut(input string tag, input bit kwEn,
                            input logic ready, input logic rv, input logic [7:0] rd,
                            input logic [7:0] pid, input logic [7:0] op,
                            input logic ws, input logic kws, input logic rs,
                            input logic ack, input logic ev);
        bit stb;
        stb = (strobeAt == cyc);
        checkOutput({tag, ".cmd_ready"}, {7'b0, ready}, {7'b0, rst && (cyc >= nextFree) && !interrupt});
        checkOutput({tag, ".rsp_valid"}, {7'b0, rv}, {7'b0, rspAt == cyc});
        checkOutput({tag, ".rsp_data"}, rd, expRsp);
        checkOutput({tag, ".port_id"}, pid, expPort);
        checkOutput({tag, ".out_port"}, op, expOut);
        checkOutput({tag, ".read_strobe"}, {7'b0, rs}, {7'b0, stb && !opW});
        checkOutput({tag, ".write_strobe"}, {7'b0, ws}, {7'b0, stb && opW && !(kwEn && opK)});
        checkOutput({tag, ".k_write_strobe"}, {7'b0, kws}, {7'b0, stb && opW && kwEn && opK});
        checkOutput({tag, ".interrupt_ack"}, {7'b0, ack}, {7'b0, ackAt == cyc});
        checkOutput({tag, ".irq_event"}, {7'b0, ev}, {7'b0, ackAt == cyc});
    endtask

    // Compare both instances against the model in the middle of every cycle
    always @(negedge clk) begin
        if (modelValid) begin
            checkDut("d0", 1'b1, cmd_ready0, rsp_valid0, rsp_data0, port_id0, out_port0,
                     write_strobe0, k_write_strobe0, read_strobe0, interrupt_ack0, irq_event0);
            checkDut("d1", 1'b0, cmd_ready1, rsp_valid1, rsp_data1, port_id1, out_port1,
                     write_strobe1, k_write_strobe1, read_strobe1, interrupt_ack1, irq_event1);
        end
    end

    task automatic applyStimulus(input bit v, input bit w, input bit k, input logic [7:0] p, input logic [7:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_kwrite = k;
        cmd_port = p;
        cmd_data = d;
    endtask

    // Advance one cycle; the responder drops interrupt two cycles after seeing ack
    task automatic step(output bit rdyWas);
        bit wasAck;
        #1;
        rdyWas = cmd_ready0;
        wasAck = interrupt_ack0;
        @(posedge clk);
        #1;
        if (ackDelay) interrupt = 1'b0;
        ackDelay = wasAck;
        #1;
    endtask

    task automatic stepN(input int n);
        bit dummy;
        for (int i = 0; i < n; i++) step(dummy);
    endtask

    // Present a command until accepted; returns the ADDR cycle number
    task automatic doCmd(input bit w, input bit k, input logic [7:0] p, input logic [7:0] d, output int accCycle);
        bit rdy;
        bit done;
        done = 1'b0;
        accCycle = -1;
        applyStimulus(1'b1, w, k, p, d);
        for (int i = 0; i < 20 && !done; i++) begin
            step(rdy);
            if (rdy) begin
                done = 1'b1;
                accCycle = cyc;
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        if (!done) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within 20 cycles (port %h)", p);
        end
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        int n;
        int acc3 [4];
        int ackBefore;
        int r;
        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
        regs[8'h0A] = 8'h3C;
        rst = 1'b0;
        interrupt = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        stepN(3);
        checkOutput("reset port_id", port_id0, 8'h00);
        checkOutput("reset cmd_ready", {7'b0, cmd_ready0}, 8'h00);
        rst = 1'b1;
        stepN(1);

        $display("[TB] single write");
        doCmd(1'b1, 1'b0, 8'h09, 8'hA5, n);
        checkOutput("t1 port_id N+1", port_id0, 8'h09);
        checkOutput("t1 out_port N+1", out_port0, 8'hA5);
        checkOutput("t1 write_strobe N+1", {7'b0, write_strobe0}, 8'h00);
        stepN(1);
        checkOutput("t1 write_strobe N+2", {7'b0, write_strobe0}, 8'h01);
        stepN(1);
        checkOutput("t1 cmd_ready N+3", {7'b0, cmd_ready0}, 8'h01);

        $display("[TB] read then write");
        doCmd(1'b0, 1'b0, 8'h0A, 8'h00, n);
        stepN(1);
        checkOutput("t2 read_strobe N+2", {7'b0, read_strobe0}, 8'h01);
        stepN(1);
        checkOutput("t2 rsp_valid N+3", {7'b0, rsp_valid0}, 8'h01);
        checkOutput("t2 rsp_data N+3", rsp_data0, 8'h3C);
        doCmd(1'b1, 1'b0, 8'h0B, 8'h77, n);
        stepN(2);
        checkOutput("t2 rsp_data hold", rsp_data0, 8'h3C);

        $display("[TB] back-to-back writes");
        for (int k = 0; k < 4; k++) doCmd(1'b1, 1'b0, 8'(8'h13 + k), 8'(8'h40 + k), acc3[k]);
        for (int k = 1; k < 4; k++) checkOutput("t3 accept spacing", 8'(acc3[k] - acc3[k-1]), 8'd3);
        stepN(2);

        $display("[TB] interrupt during strobe");
        doCmd(1'b1, 1'b0, 8'h20, 8'h11, n);
        stepN(1);
        interrupt = 1'b1;
        #1;
        checkOutput("t4 write_strobe", {7'b0, write_strobe0}, 8'h01);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h21, 8'h22);
        stepN(1);
        checkOutput("t4 cmd_ready irq", {7'b0, cmd_ready0}, 8'h00);
        stepN(1);
        checkOutput("t4 interrupt_ack", {7'b0, interrupt_ack0}, 8'h01);
        checkOutput("t4 irq_event", {7'b0, irq_event0}, 8'h01);
        doCmd(1'b1, 1'b0, 8'h21, 8'h22, r);
        checkOutput("t4 pending accept", 8'(r - n), 8'd6);
        stepN(2);

        $display("[TB] interrupt and command together");
        ackBefore = ackCount0;
        interrupt = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h30, 8'h31);
        n = cyc;
        #1;
        checkOutput("t5 cmd_ready", {7'b0, cmd_ready0}, 8'h00);
        doCmd(1'b1, 1'b0, 8'h30, 8'h31, r);
        checkOutput("t5 accept delay", 8'(r - n), 8'd4);
        stepN(2);
        checkOutput("t5 ack count", 8'(ackCount0 - ackBefore), 8'd1);

        $display("[TB] reset during read strobe, kwrite select");
        doCmd(1'b0, 1'b0, 8'h0A, 8'h00, n);
        stepN(1);
        rst = 1'b0;
        stepN(1);
        checkOutput("t6 read_strobe", {7'b0, read_strobe0}, 8'h00);
        checkOutput("t6 rsp_valid", {7'b0, rsp_valid0}, 8'h00);
        checkOutput("t6 rsp_data", rsp_data0, 8'h00);
        checkOutput("t6 port_id", port_id0, 8'h00);
        rst = 1'b1;
        stepN(1);
        checkOutput("t6 rsp_valid after", {7'b0, rsp_valid0}, 8'h00);
        doCmd(1'b1, 1'b1, 8'h40, 8'h55, n);
        stepN(1);
        checkOutput("t6 d0 k_write_strobe", {7'b0, k_write_strobe0}, 8'h01);
        checkOutput("t6 d0 write_strobe", {7'b0, write_strobe0}, 8'h00);
        checkOutput("t6 d1 write_strobe", {7'b0, write_strobe1}, 8'h01);
        checkOutput("t6 d1 k_write_strobe", {7'b0, k_write_strobe1}, 8'h00);
        stepN(1);

        $display("[TB] random traffic");
        for (int it = 0; it < 300; it++) begin
            if (!interrupt && $urandom_range(0, 7) == 0) interrupt = 1'b1;
            r = $urandom_range(0, 19);
            if (r < 12) begin
                doCmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), n);
            end else if (r < 19) begin
                stepN(1);
            end else begin
                rst = 1'b0;
                stepN(1);
                rst = 1'b1;
            end
        end
        stepN(6);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
